// File: rtl/fft_spectrum_peak_if.sv
// Stream bundle for fft_spectrum_peak: FFT bins in, per-bin power and frame peak out.
// The DUT side uses the slave modport, the bin source / result sink uses master.
interface fft_spectrum_peak_if #(
  parameter int LOGS_FFT_LEN = 10,
  parameter int INPUT_WIDTH  = 16
);
  localparam int IDX_W = LOGS_FFT_LEN;
  localparam int PWR_W = 2 * INPUT_WIDTH;

  logic               i_axi4s_data_tvalid;
  logic [PWR_W-1:0]   i_axi4s_data_tdata;
  logic               i_axi4s_data_tlast;
  logic [23:0]        i_axi4s_data_tuser;

  logic               o_pwr_vld;
  logic [PWR_W-1:0]   o_pwr;
  logic [IDX_W-1:0]   o_pwr_index;
  logic               o_pwr_last;

  logic               o_peak_vld;
  logic [IDX_W-1:0]   o_peak_index;
  logic [PWR_W-1:0]   o_peak_pwr;
  logic [4:0]         o_peak_exp;
  logic               o_frame_err;

  modport master (
    output i_axi4s_data_tvalid, i_axi4s_data_tdata, i_axi4s_data_tlast, i_axi4s_data_tuser,
    input  o_pwr_vld, o_pwr, o_pwr_index, o_pwr_last,
    input  o_peak_vld, o_peak_index, o_peak_pwr, o_peak_exp, o_frame_err
  );

  modport slave (
    input  i_axi4s_data_tvalid, i_axi4s_data_tdata, i_axi4s_data_tlast, i_axi4s_data_tuser,
    output o_pwr_vld, o_pwr, o_pwr_index, o_pwr_last,
    output o_peak_vld, o_peak_index, o_peak_pwr, o_peak_exp, o_frame_err
  );
endinterface

// File: rtl/fft_spectrum_peak.sv
// Per-bin power (re^2+im^2) through a 3-stage pipeline, plus a per-frame peak search
// with frame-integrity checking and a one-cycle peak report after each tlast.
module fft_spectrum_peak #(
  parameter int LOGS_FFT_LEN = 10,
  parameter int INPUT_WIDTH  = 16,
  parameter int SKIP_DC      = 1
) (
  input  logic               i_aclk,
  input  logic               i_aresetn,
  fft_spectrum_peak_if.slave bus
);
  localparam int IW     = INPUT_WIDTH;
  localparam int PW     = 2 * IW;
  localparam int IDXW   = LOGS_FFT_LEN;
  localparam int EW     = 5;
  localparam int STAGES = 3;
  localparam logic [IDXW-1:0] LAST_IDX = '1;

  typedef struct packed {
    logic            last;
    logic [EW-1:0]   exp;
    logic [IDXW-1:0] idx;
  } side_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  // ---------------- power pipeline ----------------
  logic [STAGES:1]    vld_pipe;
  side_t              side_in, s1_side, s2_side, s3_side;
  logic signed [IW-1:0] s1_re, s1_im;
  logic signed [PW-1:0] re_x, im_x;
  logic [PW-1:0]      s2_re2, s2_im2, pwr_q;
  logic               unused_tuser;

  assign side_in.last = bus.i_axi4s_data_tlast;
  assign side_in.exp  = bus.i_axi4s_data_tuser[16 +: EW];
  assign side_in.idx  = bus.i_axi4s_data_tuser[IDXW-1:0];
  assign unused_tuser = ^{bus.i_axi4s_data_tuser[23:21], bus.i_axi4s_data_tuser[15:IDXW]};

  // Squares are taken at full width; each is at most 2^(PW-2), so the sum cannot overflow.
  assign re_x = {{IW{s1_re[IW-1]}}, s1_re};
  assign im_x = {{IW{s1_im[IW-1]}}, s1_im};

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      vld_pipe <= '0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_side  <= '0;
      s2_re2   <= '0;
      s2_im2   <= '0;
      s2_side  <= '0;
      pwr_q    <= '0;
      s3_side  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_axi4s_data_tvalid};
      if (bus.i_axi4s_data_tvalid) begin
        s1_re   <= bus.i_axi4s_data_tdata[IW-1:0];
        s1_im   <= bus.i_axi4s_data_tdata[IW +: IW];
        s1_side <= side_in;
      end
      if (vld_pipe[1]) begin
        s2_re2  <= re_x * re_x;
        s2_im2  <= im_x * im_x;
        s2_side <= s1_side;
      end
      if (vld_pipe[2]) begin
        pwr_q   <= s2_re2 + s2_im2;
        s3_side <= s2_side;
      end
    end
  end

  assign bus.o_pwr_vld   = vld_pipe[STAGES];
  assign bus.o_pwr       = pwr_q;
  assign bus.o_pwr_index = s3_side.idx;
  assign bus.o_pwr_last  = vld_pipe[STAGES] & s3_side.last;

  // ---------------- peak search FSM (works on power-stage beats) ----------------
  state_t          state_q, state_d;
  logic [PW-1:0]   run_pwr_q, run_pwr_d;
  logic [IDXW-1:0] run_idx_q, run_idx_d;
  logic [IDXW-1:0] prev_idx_q, prev_idx_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            err_d, rpt_load, frame_err_q;
  logic            beat, dc_skip, last_bad;

  logic [IDXW-1:0] peak_idx_q;
  logic [PW-1:0]   peak_pwr_q;
  logic [EW-1:0]   peak_exp_q;

  assign beat     = vld_pipe[STAGES];
  assign dc_skip  = (SKIP_DC != 0) && (s3_side.idx == '0);
  assign last_bad = s3_side.last != (s3_side.idx == LAST_IDX);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= IDLE;
      run_pwr_q   <= '0;
      run_idx_q   <= '0;
      prev_idx_q  <= '0;
      exp_q       <= '0;
      frame_err_q <= 1'b0;
      peak_idx_q  <= '0;
      peak_pwr_q  <= '0;
      peak_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_pwr_q   <= run_pwr_d;
      run_idx_q   <= run_idx_d;
      prev_idx_q  <= prev_idx_d;
      exp_q       <= exp_d;
      frame_err_q <= frame_err_q | err_d;
      if (rpt_load) begin
        peak_idx_q <= run_idx_d;
        peak_pwr_q <= run_pwr_d;
        peak_exp_q <= exp_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    run_pwr_d  = run_pwr_q;
    run_idx_d  = run_idx_q;
    prev_idx_d = prev_idx_q;
    exp_d      = exp_q;
    err_d      = 1'b0;
    rpt_load   = beat && s3_side.last;
    case (state_q)
      // REPORT lasts one cycle but still accepts a new frame's first beat.
      IDLE, REPORT: begin
        state_d = IDLE;
        if (beat) begin
          exp_d      = s3_side.exp;
          prev_idx_d = s3_side.idx;
          run_idx_d  = s3_side.idx;
          run_pwr_d  = dc_skip ? '0 : pwr_q;
          err_d      = (s3_side.idx != '0) || last_bad;
          state_d    = s3_side.last ? REPORT : ACTIVE;
        end
      end
      ACTIVE: begin
        if (beat) begin
          prev_idx_d = s3_side.idx;
          // Strictly greater keeps the lowest index on ties.
          if (!dc_skip && (pwr_q > run_pwr_q)) begin
            run_pwr_d = pwr_q;
            run_idx_d = s3_side.idx;
          end
          err_d = (s3_side.idx != prev_idx_q + IDXW'(1)) || (s3_side.exp != exp_q) || last_bad;
          if (s3_side.last) state_d = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_peak_vld   = (state_q == REPORT);
  assign bus.o_peak_index = peak_idx_q;
  assign bus.o_peak_pwr   = peak_pwr_q;
  assign bus.o_peak_exp   = peak_exp_q;
  assign bus.o_frame_err  = frame_err_q;

endmodule
